pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage LC-3b pipeline. Generates the per-register `stall_pipeline` enables for IF/ID, ID/EX, EX/MEM and MEM/WB, the PC load enable, bubble-insertion and flush controls. Inputs are the I-cache and D-cache handshakes, the load-use hazard detector and branch resolution. It tracks outstanding cache misses and wrong-path fetches across cycles, and runs a miss watchdog.

## Interface
Parameters:
- `WDOG_LIMIT`, 255: cycles a single miss may stay outstanding before `wdog_err` sets.

Ports:
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `icache_req` in 1: IF stage has a fetch outstanding.
- `icache_resp` in 1: fetch data valid this cycle.
- `dcache_req` in 1: MEM stage read/write outstanding.
- `dcache_resp` in 1: D-cache access complete this cycle.
- `load_use` in 1: ID-stage instruction needs a load result still in EX.
- `branch_taken` in 1: control transfer resolved taken in MEM (BR/JMP/JSR/TRAP).
- `pc_load_en` out 1: PC may update.
- `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb` out 1 each: hold the corresponding pipeline register.
- `bubble_id_ex` out 1: ID/EX loads a NOP control word (`load_regfile`=0, no memory op).
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem` out 1 each: the register loads a NOP on the next edge.
- `wdog_err` out 1: sticky watchdog error.
- `stall_cycles` out 16, `flush_count` out 16: present only with `HAZARD_PERF_EN`.

## Operation
- States: `RUN`, `DMISS`, `IMISS`, `IMISS_SQUASH`.
- Priority each cycle: `reset` > D-stall > branch flush > I-stall > load-use.
- **D-stall** (`dcache_req & ~dcache_resp`):
  - All four `stall_*`=1, `pc_load_en`=0, no flush, no bubble.
  - State `DMISS`, which it leaves on `dcache_resp`.
  - Held `branch_taken` is acted on in the cycle the stall releases.
- **Branch flush** (`branch_taken`, no D-stall):
  - `flush_if_id`=`flush_id_ex`=`flush_ex_mem`=1 and `pc_load_en`=1, for exactly one cycle.
  - If an I-miss is outstanding with no response this cycle, go to `IMISS_SQUASH`.
- **I-stall** (`icache_req & ~icache_resp`, state `RUN`/`IMISS`):
  - `pc_load_en`=0, `stall_if_id`=1, `bubble_id_ex`=1.
  - EX/MEM and MEM/WB advance.
  - State `IMISS`.
- **IMISS_SQUASH**: the in-flight fetch is wrong-path.
  - Hold PC, assert `flush_if_id` every cycle, `bubble_id_ex`=1.
  - On `icache_resp`: discard the data, assert `pc_load_en` so the PC advances to the branch target fetch, return to `RUN`.
- **Load-use** (state `RUN`, no higher event):
  - `pc_load_en`=0, `stall_if_id`=1, `bubble_id_ex`=1.
  - One bubble per asserted cycle; no state change.
- **Watchdog**:
  - 8-bit counter; clears on entering or leaving any miss state, increments each cycle in `DMISS`/`IMISS`/`IMISS_SQUASH`, saturates.
  - `wdog_err` sets when the count reaches `WDOG_LIMIT`.
  - `wdog_err` clears only on `reset`.

## Timing
- All outputs are Mealy: combinational from state plus current inputs, with zero-cycle latency to cache handshakes. A response cycle releases the stall in that same cycle.
- State, watchdog and counters update on `posedge clk`.
- Reset values while `reset`=1:
  - State `RUN`, watchdog 0, `wdog_err`=0, counters 0.
  - `flush_if_id`=`flush_id_ex`=`flush_ex_mem`=1; all `stall_*`=0, `bubble_id_ex`=0, `pc_load_en`=0.
- Reset mid-miss abandons the miss: state returns to `RUN`, no squash pending.
- Outcomes when events coincide:
  - `dcache_resp` and `branch_taken` in the same cycle: release and flush occur together in that cycle.
  - `icache_resp` and `branch_taken` in the same cycle: flush only, state `RUN`; the response is discarded by `flush_if_id`.
  - `load_use` during I-stall: I-stall outputs apply (identical bubble).
  - `load_use` together with `branch_taken`: the flush wins; no bubble in addition to the flush.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_load_en`=0 outside reset.
  - `flush_count` increments on each branch-flush cycle.
  - Both are 16-bit, saturate at 0xFFFF and reset to 0.
- `HAZARD_PERF_EN` undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- D-miss: `dcache_req`=1 for 5 cycles, `dcache_resp` on the 5th. All four stalls are 1 for cycles 1–4 and 0 on cycle 5; the state returns to `RUN`.
- Branch during D-miss: `branch_taken`=1 throughout a 3-cycle D-miss. No flush during cycles 1–2; the three flushes plus `pc_load_en`=1 occur on the release cycle 3 only.
- Squash: I-miss outstanding, `branch_taken` pulses for 1 cycle, `icache_resp` arrives 4 cycles later. `flush_if_id`=1 on all 5 cycles, `pc_load_en`=1 on the branch cycle and the response cycle, then `RUN`.
- Load-use: `load_use` for 1 cycle in `RUN`. Exactly one `bubble_id_ex`=1 with `stall_if_id`=1 and `pc_load_en`=0; the next cycle is all-clear.
- Watchdog: `WDOG_LIMIT`=10, `dcache_req` held with no response. `wdog_err` rises after the 10th miss cycle and stays 1 after the response; it clears only on `reset`.
- Reset mid-miss: `reset` in cycle 3 of an I-miss. Next cycle shows state `RUN`, all flushes asserted during reset, `stall_cycles`=0 (with `HAZARD_PERF_EN`).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline (cache misses, load-use, branch flush, miss watchdog).
// Define HAZARD_PERF_EN to add the stall_cycles / flush_count performance counters.

module pipeline_hazard_ctrl #(
    parameter int WDOG_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        icache_req,
    input  logic        icache_resp,
    input  logic        dcache_req,
    input  logic        dcache_resp,
    input  logic        load_use,
    input  logic        branch_taken,
    output logic        pc_load_en,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        stall_mem_wb,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        wdog_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [1:0] ST_RUN          = 2'd0;
    localparam logic [1:0] ST_DMISS        = 2'd1;
    localparam logic [1:0] ST_IMISS        = 2'd2;
    localparam logic [1:0] ST_IMISS_SQUASH = 2'd3;

    localparam logic [7:0] WDOG_LIMIT_C = 8'(WDOG_LIMIT);

    logic [1:0] state_q, state_d;
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic       wdog_err_q, wdog_err_d;
    logic       d_stall;
    logic       i_stall;
    logic       miss_next;

    assign d_stall = dcache_req & ~dcache_resp;
    assign i_stall = icache_req & ~icache_resp;

    always_comb begin
        pc_load_en   = 1'b1;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        state_d      = ST_RUN;

        if (reset) begin
            pc_load_en   = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (d_stall) begin
            // A held branch_taken waits here and is acted on in the release cycle.
            pc_load_en   = 1'b0;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
            state_d      = ST_DMISS;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_d      = i_stall ? ST_IMISS_SQUASH : ST_RUN;
        end else if (state_q == ST_IMISS_SQUASH) begin
            // Wrong-path fetch still in flight: keep dropping it until it returns.
            pc_load_en   = icache_resp;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            state_d      = icache_resp ? ST_RUN : ST_IMISS_SQUASH;
        end else if (i_stall) begin
            pc_load_en   = 1'b0;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            state_d      = ST_IMISS;
        end else if (load_use) begin
            pc_load_en   = 1'b0;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    // Counter measures the current miss episode; any state change restarts it.
    assign miss_next = (state_d != ST_RUN);

    always_comb begin
        wdog_cnt_d = 8'd0;
        if (miss_next) begin
            if (state_d != state_q) begin
                wdog_cnt_d = 8'd1;
            end else if (wdog_cnt_q != 8'hFF) begin
                wdog_cnt_d = wdog_cnt_q + 8'd1;
            end else begin
                wdog_cnt_d = wdog_cnt_q;
            end
        end
        wdog_err_d = wdog_err_q | (miss_next & (wdog_cnt_d == WDOG_LIMIT_C));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wdog_cnt_q <= 8'd0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q & ~reset;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        branch_flush;

    assign branch_flush = ~reset & ~d_stall & branch_taken;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (~pc_load_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (branch_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = reset ? 16'd0 : stall_cycles_q;
    assign flush_count  = reset ? 16'd0 : flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand sequences, then randomized traffic vs a reference model.
// Honours HAZARD_PERF_EN the same way as the design.

module tb_pipeline_hazard_ctrl;

    localparam int LIMIT = 10;

    // Output vector order: pc_load_en, stall if/id, id/ex, ex/mem, mem/wb, bubble, flush if/id, id/ex, ex/mem
    localparam logic [8:0] O_RESET   = 9'b000000111;
    localparam logic [8:0] O_CLEAR   = 9'b100000000;
    localparam logic [8:0] O_DSTALL  = 9'b011110000;
    localparam logic [8:0] O_FLUSH   = 9'b100000111;
    localparam logic [8:0] O_ISTALL  = 9'b010001000;
    localparam logic [8:0] O_SQ_WAIT = 9'b000001100;
    localparam logic [8:0] O_SQ_REL  = 9'b100001100;

    // Input vector order: reset, icache_req, icache_resp, dcache_req, dcache_resp, load_use, branch_taken
    localparam logic [6:0] I_IDLE  = 7'b0000000;
    localparam logic [6:0] I_RST   = 7'b1000000;
    localparam logic [6:0] I_D     = 7'b0001000;
    localparam logic [6:0] I_DR    = 7'b0001100;
    localparam logic [6:0] I_DB    = 7'b0001001;
    localparam logic [6:0] I_DRB   = 7'b0001101;
    localparam logic [6:0] I_I     = 7'b0100000;
    localparam logic [6:0] I_IB    = 7'b0100001;
    localparam logic [6:0] I_IR    = 7'b0110000;
    localparam logic [6:0] I_IRB   = 7'b0110001;
    localparam logic [6:0] I_LU    = 7'b0000010;
    localparam logic [6:0] I_LUB   = 7'b0000011;
    localparam logic [6:0] I_ILU   = 7'b0100010;
    localparam logic [6:0] I_ID    = 7'b0101000;
    localparam logic [6:0] I_IDR   = 7'b0101100;
    localparam logic [6:0] I_IRST  = 7'b1100000;

    typedef struct {
        string      tag;
        logic [6:0] in;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic icache_req = 1'b0, icache_resp = 1'b0, dcache_req = 1'b0, dcache_resp = 1'b0;
    logic load_use = 1'b0, branch_taken = 1'b0;
    logic pc_load_en, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, wdog_err;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_count;
`endif
    logic [8:0] act_outs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_sq = 1'b0;
    bit m_err = 1'b0;
    int m_len = 0;
    int m_prev_kind = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .icache_req   (icache_req),
        .icache_resp  (icache_resp),
        .dcache_req   (dcache_req),
        .dcache_resp  (dcache_resp),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .pc_load_en   (pc_load_en),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .stall_mem_wb (stall_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .wdog_err     (wdog_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    assign act_outs = {pc_load_en, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                       bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        reset        = in[6];
        icache_req   = in[5];
        icache_resp  = in[4];
        dcache_req   = in[3];
        dcache_resp  = in[2];
        load_use     = in[1];
        branch_taken = in[0];
    endtask

    task automatic step(input string tag, input logic [6:0] in, input logic [8:0] exp, input logic exp_err);
        drive(in);
        @(negedge clk);
        $display("[%0t] %s in=%b outs=%b wdog_err=%b", $time, tag, in, act_outs, wdog_err);
        chk({tag, ".outs"}, 32'(act_outs), 32'(exp));
        chk({tag, ".wdog_err"}, 32'(wdog_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string tag, input logic [6:0] in, input logic [8:0] exp);
        vec_t v;
        v.tag = tag;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    // One cycle of random traffic checked against the rule-level model.
    // Episode tags: 0 none, 1 D-miss, 2 I-miss, 3 wrong-path fetch pending.
    task automatic rand_cycle(input logic [6:0] in);
        logic [8:0] o;
        int  kind;
        bit  nsq;
        bit  rst, ireq, iresp, dreq, dresp, lu, br, flushed;
        {rst, ireq, iresp, dreq, dresp, lu, br} = in;
        kind = 0;
        nsq = m_sq;
        flushed = 1'b0;
        if (rst) begin
            o = O_RESET;
            nsq = 1'b0;
        end else if (dreq && !dresp) begin
            o = O_DSTALL;
            kind = 1;
            nsq = 1'b0;
        end else if (br) begin
            o = O_FLUSH;
            flushed = 1'b1;
            nsq = ireq && !iresp;
            kind = nsq ? 3 : 0;
        end else if (m_sq) begin
            o = iresp ? O_SQ_REL : O_SQ_WAIT;
            nsq = !iresp;
            kind = nsq ? 3 : 0;
        end else if (ireq && !iresp) begin
            o = O_ISTALL;
            kind = 2;
        end else if (lu) begin
            o = O_ISTALL;
        end else begin
            o = O_CLEAR;
        end

        drive(in);
        @(negedge clk);
        chk("rand.outs", 32'(act_outs), 32'(o));
        chk("rand.wdog_err", 32'(wdog_err), rst ? 32'd0 : 32'(m_err));
`ifdef HAZARD_PERF_EN
        chk("rand.stall_cycles", 32'(stall_cycles), rst ? 32'd0 : 32'(m_stall));
        chk("rand.flush_count", 32'(flush_count), rst ? 32'd0 : 32'(m_flush));
`endif

        if (rst) begin
            m_len = 0;
            m_err = 1'b0;
            m_stall = 0;
            m_flush = 0;
            m_prev_kind = 0;
        end else begin
            if (kind == 0) m_len = 0;
            else if (kind == m_prev_kind) m_len = (m_len < 255) ? m_len + 1 : 255;
            else m_len = 1;
            if (kind != 0 && m_len == LIMIT) m_err = 1'b1;
            if (!o[8] && m_stall < 65535) m_stall++;
            if (flushed && m_flush < 65535) m_flush++;
            m_prev_kind = kind;
        end
        m_sq = nsq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        int d_left, i_left;
        logic [6:0] rin;

        tbl.push_back(mk("reset",     I_RST,  O_RESET));
        tbl.push_back(mk("idle",      I_IDLE, O_CLEAR));
        tbl.push_back(mk("dmiss1",    I_D,    O_DSTALL));
        tbl.push_back(mk("dmiss2",    I_D,    O_DSTALL));
        tbl.push_back(mk("dmiss3",    I_D,    O_DSTALL));
        tbl.push_back(mk("dmiss4",    I_D,    O_DSTALL));
        tbl.push_back(mk("dmiss5",    I_DR,   O_CLEAR));
        tbl.push_back(mk("dmiss_run", I_IDLE, O_CLEAR));
        tbl.push_back(mk("brd1",      I_DB,   O_DSTALL));
        tbl.push_back(mk("brd2",      I_DB,   O_DSTALL));
        tbl.push_back(mk("brd3",      I_DRB,  O_FLUSH));
        tbl.push_back(mk("brd_run",   I_IDLE, O_CLEAR));
        tbl.push_back(mk("sq_imiss",  I_I,    O_ISTALL));
        tbl.push_back(mk("sq1",       I_IB,   O_FLUSH));
        tbl.push_back(mk("sq2",       I_I,    O_SQ_WAIT));
        tbl.push_back(mk("sq3",       I_I,    O_SQ_WAIT));
        tbl.push_back(mk("sq4",       I_I,    O_SQ_WAIT));
        tbl.push_back(mk("sq5",       I_IR,   O_SQ_REL));
        tbl.push_back(mk("sq_run",    I_IDLE, O_CLEAR));
        tbl.push_back(mk("lu",        I_LU,   O_ISTALL));
        tbl.push_back(mk("lu_after",  I_IDLE, O_CLEAR));
        tbl.push_back(mk("ibr0",      I_I,    O_ISTALL));
        tbl.push_back(mk("ibr1",      I_IRB,  O_FLUSH));
        tbl.push_back(mk("ibr_run",   I_IDLE, O_CLEAR));
        tbl.push_back(mk("lubr",      I_LUB,  O_FLUSH));
        tbl.push_back(mk("lubr_run",  I_IDLE, O_CLEAR));
        tbl.push_back(mk("ilu",       I_ILU,  O_ISTALL));
        tbl.push_back(mk("ilu_resp",  I_IR,   O_CLEAR));
        tbl.push_back(mk("di1",       I_ID,   O_DSTALL));
        tbl.push_back(mk("di2",       I_IDR,  O_ISTALL));
        tbl.push_back(mk("di3",       I_IR,   O_CLEAR));
        tbl.push_back(mk("sqrst0",    I_I,    O_ISTALL));
        tbl.push_back(mk("sqrst1",    I_IB,   O_FLUSH));
        tbl.push_back(mk("sqrst2",    I_I,    O_SQ_WAIT));
        tbl.push_back(mk("sqrst3",    I_IRST, O_RESET));
        tbl.push_back(mk("sqrst_run", I_IDLE, O_CLEAR));

        @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i].tag, tbl[i].in, tbl[i].exp, 1'b0);

        // Reset in cycle 3 of an I-miss.
        step("rmm1", I_I, O_ISTALL, 1'b0);
        step("rmm2", I_I, O_ISTALL, 1'b0);
        step("rmm3", I_IRST, O_RESET, 1'b0);
        step("rmm_run", I_IDLE, O_CLEAR, 1'b0);
`ifdef HAZARD_PERF_EN
        chk("rmm.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rmm.flush_count", 32'(flush_count), 32'd0);
`endif

        // Watchdog: D-miss held past LIMIT cycles, then response, then reset.
        for (int k = 1; k <= 12; k++) step($sformatf("wd%0d", k), I_D, O_DSTALL, k >= 11);
        step("wd_resp", I_DR, O_CLEAR, 1'b1);
        step("wd_hold1", I_IDLE, O_CLEAR, 1'b1);
        step("wd_hold2", I_IDLE, O_CLEAR, 1'b1);
        step("wd_reset", I_RST, O_RESET, 1'b0);
        step("wd_clear", I_IDLE, O_CLEAR, 1'b0);

        // Randomized traffic; model starts from a reset cycle.
        rand_cycle(I_RST);
        d_left = -1;
        i_left = -1;
        for (int c = 0; c < 4000; c++) begin
            if (d_left < 0 && $urandom_range(0, 7) == 0) d_left = int'($urandom_range(0, 14));
            if (i_left < 0 && $urandom_range(0, 3) == 0) i_left = int'($urandom_range(0, 6));
            rin[6] = ($urandom_range(0, 299) == 0);
            rin[5] = (i_left >= 0);
            rin[4] = (i_left == 0) || ($urandom_range(0, 63) == 0);
            rin[3] = (d_left >= 0);
            rin[2] = (d_left == 0);
            rin[1] = ($urandom_range(0, 7) == 0);
            rin[0] = ($urandom_range(0, 9) == 0);
            rand_cycle(rin);
            if (d_left >= 0) d_left--;
            if (i_left >= 0) i_left--;
            if (rin[6]) begin
                d_left = -1;
                i_left = -1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
